operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter NREG, default 32, register count (5-bit addresses).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the decoded-instruction handshake.
REQ-006 SHALL have ports in_opcode input 5, in_rs input 5, in_rt input 5, in_rd input 5: ALU opcode, source A, source B and destination addresses.
REQ-007 SHALL have ports in_imm input 16, in_use_imm input 1 (B from immediate), in_sign_ext input 1 (sign- vs zero-extend), in_wr input 1 (instruction writes rd).
REQ-008 SHALL have ports wb_en input 1, wb_addr input 5, wb_data input DATA_W: the writeback port from the downstream stage.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, the handshake toward the ALU.
REQ-010 SHALL have ports out_a output DATA_W, out_b output DATA_W, out_opcode output 5, out_rd output 5, out_wr output 1, all registered.

Function
REQ-011 SHALL hold NREG x DATA_W registers; r0 reads 0; writes to r0 are ignored.
REQ-012 SHALL write wb_data to wb_addr at the clock edge when wb_en=1 and wb_addr!=0.
REQ-013 SHALL bypass writes on reads: if wb_en=1, wb_addr==rs/rt and the address is nonzero, the read returns wb_data in the same cycle.
REQ-014 SHALL keep a busy bit per register: set busy[rd] on accept with in_wr=1 and rd!=0; clear busy[wb_addr] on wb_en=1; busy[0] is always 0.
REQ-015 SHALL give set priority when a set and a clear hit the same address in one cycle, so the bit stays 1.
REQ-016 SHALL assert hazard when any of the following holds, where a register counts as not busy if wb_en=1 and wb_addr equals it in that cycle:
- busy[rs];
- busy[rt] with in_use_imm=0;
- busy[rd] with in_wr=1 (WAW).
REQ-017 SHALL drive in_ready = !reset && !hazard && (!out_valid || out_ready), combinationally.
REQ-018 SHALL accept when in_valid && in_ready, and load on that edge:
- out_a = value of rs;
- out_b = extended imm if in_use_imm=1, else value of rt;
- opcode, rd and wr passed through;
- out_valid=1.
REQ-019 SHALL extend the immediate as {16{imm[15]}},imm when in_sign_ext=1, else as 16'b0,imm.
REQ-020 SHALL have a latency of exactly 1 cycle from accept to out_valid.
REQ-021 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-022 SHALL clear out_valid when out_valid && out_ready and there is no accept in the same cycle.
REQ-023 SHALL sustain back-to-back accepts (out_ready held 1, no hazards) at one instruction per cycle.

Reset
REQ-024 SHALL on reset clear all registers, all busy bits, out_valid, out_a, out_b, out_opcode, out_rd and out_wr to 0.
REQ-025 SHALL drive in_ready=0 during reset and ignore wb_en during reset.
REQ-026 SHALL discard any in-flight output on reset mid-operation; the first accept is possible in the cycle after reset deasserts.

Structure
REQ-027 SHALL use a shared package holding DATA_W, the register address width and the 5-bit ALU opcode constants (add, addinc, inca, subdec, sub, deca, lsl, asr, logic ops, beq, bne, jump), shared with the ALU.
REQ-028 SHALL contain one sub-module, regfile_2r1w (2 async read ports, 1 sync write port, r0 fixed to zero, write bypass); the scoreboard, hazard logic and output register stay in operand_fetch.

Verification
REQ-029 SHALL verify basic read: reset, wb r3=0x00000005, r4=0x00000007; accept rs=3 rt=4 opcode=00000 -> next cycle out_valid=1, out_a=5, out_b=7.
REQ-030 SHALL verify immediates: imm=0x8000 with sign_ext=1 -> out_b=0xFFFF8000; with sign_ext=0 -> out_b=0x00008000; rs=0 -> out_a=0.
REQ-031 SHALL verify RAW stall: accept in_wr=1 rd=5, then an instruction with rs=5 -> in_ready=0; wb_en wb_addr=5 wb_data=0x1234 -> accepted that cycle, with out_a=0x1234 next cycle.
REQ-032 SHALL verify backpressure: out_ready=0 with out_valid=1 -> in_ready=0 and out_* unchanged for 3 cycles; out_ready=1 -> the pending instruction is accepted next.
REQ-033 SHALL verify r0: wb_en wb_addr=0 wb_data=0xFFFFFFFF -> rs=0 still reads 0; in_wr=1 rd=0 sets no busy bit (a following rs=0 is not stalled).
REQ-034 SHALL verify mid-op reset: busy[7]=1 and out_valid=1, assert reset for 1 cycle -> out_valid=0, busy cleared, r1..r31 read 0, and an instruction with rs=7 is accepted immediately.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage and the ALU.
//   ALU_DATA_W : default datapath width
//   ADDR_W     : register address width (32 registers)
//   OP_*       : 5-bit ALU opcode encodings, decoded by the ALU
//   imm_extend : widens a 16-bit immediate by sign or zero extension
package operand_fetch_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ADDR_W     = 5;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_ADDINC = 5'h01;
    localparam logic [4:0] OP_INCA   = 5'h02;
    localparam logic [4:0] OP_SUBDEC = 5'h03;
    localparam logic [4:0] OP_SUB    = 5'h04;
    localparam logic [4:0] OP_DECA   = 5'h05;
    localparam logic [4:0] OP_LSL    = 5'h06;
    localparam logic [4:0] OP_ASR    = 5'h07;
    localparam logic [4:0] OP_AND    = 5'h08;
    localparam logic [4:0] OP_OR     = 5'h09;
    localparam logic [4:0] OP_XOR    = 5'h0A;
    localparam logic [4:0] OP_NOT    = 5'h0B;
    localparam logic [4:0] OP_BEQ    = 5'h0C;
    localparam logic [4:0] OP_BNE    = 5'h0D;
    localparam logic [4:0] OP_JUMP   = 5'h0E;

    // Widen a 16-bit immediate to the default datapath width.
    function automatic logic [ALU_DATA_W-1:0] imm_extend(input logic [15:0] imm,
                                                         input logic        sign_ext);
        logic [ALU_DATA_W-1:0] res;
        if (sign_ext) begin
            res = {{(ALU_DATA_W-16){imm[15]}}, imm};
        end else begin
            res = {{(ALU_DATA_W-16){1'b0}}, imm};
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two asynchronous read ports and one synchronous write port.
// Register 0 is hard-wired to zero. A write in progress is forwarded to a read
// of the same (nonzero) address in the same cycle.
//   clock, reset  : rising-edge clock, synchronous active-high clear of all entries
//   we/waddr/wdata: write port
//   ra_a/rd_a     : read port A
//   ra_b/rd_b     : read port B
module regfile_2r1w
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREG   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra_a,
    input  logic [ADDR_W-1:0] ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    logic [DATA_W-1:0] mem_r [NREG];

    // Storage update: clear everything on reset, otherwise write any nonzero address.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we && (waddr != {ADDR_W{1'b0}})) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port A: zero register, then same-cycle write forwarding, then storage.
    always_comb begin
        rd_a = {DATA_W{1'b0}};
        if (ra_a == {ADDR_W{1'b0}}) begin
            rd_a = {DATA_W{1'b0}};
        end else if (we && (waddr == ra_a)) begin
            rd_a = wdata;
        end else begin
            rd_a = mem_r[ra_a];
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        rd_b = {DATA_W{1'b0}};
        if (ra_b == {ADDR_W{1'b0}}) begin
            rd_b = {DATA_W{1'b0}};
        end else if (we && (waddr == ra_b)) begin
            rd_b = wdata;
        end else begin
            rd_b = mem_r[ra_b];
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads source operands for a decoded instruction, tracks
// pending destination writes with a per-register busy scoreboard, stalls on
// RAW/WAW hazards and hands a registered operand bundle to the ALU.
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        : decoded-instruction handshake
//   in_opcode/rs/rt/rd       : opcode, source A, source B, destination
//   in_imm/use_imm/sign_ext  : immediate operand selection and extension
//   in_wr                    : instruction writes rd
//   wb_en/wb_addr/wb_data    : writeback from the downstream stage
//   out_valid/out_ready      : handshake toward the ALU
//   out_a/out_b/out_opcode/out_rd/out_wr : registered operand bundle
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREG   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_use_imm,
    input  logic              in_sign_ext,
    input  logic              in_wr,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [4:0]        out_opcode,
    output logic [4:0]        out_rd,
    output logic              out_wr
);

    logic              wb_we_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;
    logic [DATA_W-1:0] imm_ext_s;
    logic              hazard_s;
    logic              accept_s;
    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   busy_nxt_s;

    // Writeback is ignored while reset is held, both for storage and the scoreboard.
    assign wb_we_s = wb_en && !reset;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clock (clock),
        .reset (reset),
        .we    (wb_we_s),
        .waddr (wb_addr),
        .wdata (wb_data),
        .ra_a  (in_rs),
        .ra_b  (in_rt),
        .rd_a  (rs_val_s),
        .rd_b  (rt_val_s)
    );

    // Immediate widening to the datapath width.
    always_comb begin
        imm_ext_s = {DATA_W{1'b0}};
        if (in_sign_ext) begin
            imm_ext_s = {{(DATA_W-16){in_imm[15]}}, in_imm};
        end else begin
            imm_ext_s = {{(DATA_W-16){1'b0}}, in_imm};
        end
    end

    // Hazard detection; a register being written back this cycle already counts as free.
    always_comb begin
        hazard_s = 1'b0;
        if (busy_r[in_rs] && !(wb_we_s && (wb_addr == in_rs))) begin
            hazard_s = 1'b1;
        end else if (!in_use_imm && busy_r[in_rt] && !(wb_we_s && (wb_addr == in_rt))) begin
            hazard_s = 1'b1;
        end else if (in_wr && busy_r[in_rd] && !(wb_we_s && (wb_addr == in_rd))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign in_ready = !reset && !hazard_s && (!out_valid || out_ready);
    assign accept_s = in_valid && in_ready;

    // Scoreboard next state: a new claim on rd outranks a writeback clearing it.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 1; i < NREG; i++) begin
            if (accept_s && in_wr && (in_rd == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (wb_we_s && (wb_addr == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Output bundle: load on accept, drop valid once consumed, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_a      <= {DATA_W{1'b0}};
            out_b      <= {DATA_W{1'b0}};
            out_opcode <= 5'd0;
            out_rd     <= 5'd0;
            out_wr     <= 1'b0;
        end else if (accept_s) begin
            out_valid  <= 1'b1;
            out_a      <= rs_val_s;
            out_b      <= in_use_imm ? imm_ext_s : rt_val_s;
            out_opcode <= in_opcode;
            out_rd     <= in_rd;
            out_wr     <= in_wr;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a table of independent instructions issued
// back to back, then hand-written sequences for hazards, backpressure, r0 and
// mid-operation reset.
module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode, in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic        in_use_imm, in_sign_ext, in_wr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_opcode, out_rd;
    logic        out_wr;

    int checks   = 0;
    int failures = 0;

    operand_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .in_use_imm  (in_use_imm),
        .in_sign_ext (in_sign_ext),
        .in_wr       (in_wr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_wr      (out_wr)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rs, rt, rd, op;
        logic [15:0] imm;
        logic        use_imm, sx, wr;
        logic [31:0] a, b;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] op, input logic [15:0] imm,
                         input logic use_imm, input logic sx, input logic wr);
        in_rs = rs; in_rt = rt; in_rd = rd; in_opcode = op; in_imm = imm;
        in_use_imm = use_imm; in_sign_ext = sx; in_wr = wr; in_valid = 1'b1;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        wb_en = 1'b1; wb_addr = addr; wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{rs:5'd3,  rt:5'd4,  rd:5'd1, op:5'h00, imm:16'h0000, use_imm:1'b0, sx:1'b0, wr:1'b0, a:32'h00000005, b:32'h00000007};
        vecs[1] = '{rs:5'd0,  rt:5'd4,  rd:5'd2, op:5'h01, imm:16'h8000, use_imm:1'b1, sx:1'b1, wr:1'b0, a:32'h00000000, b:32'hFFFF8000};
        vecs[2] = '{rs:5'd0,  rt:5'd4,  rd:5'd3, op:5'h02, imm:16'h8000, use_imm:1'b1, sx:1'b0, wr:1'b0, a:32'h00000000, b:32'h00008000};
        vecs[3] = '{rs:5'd10, rt:5'd11, rd:5'd4, op:5'h04, imm:16'h0000, use_imm:1'b0, sx:1'b0, wr:1'b0, a:32'hDEADBEEF, b:32'h00000010};
        vecs[4] = '{rs:5'd11, rt:5'd10, rd:5'd5, op:5'h08, imm:16'h7FFF, use_imm:1'b1, sx:1'b1, wr:1'b0, a:32'h00000010, b:32'h00007FFF};
        vecs[5] = '{rs:5'd4,  rt:5'd3,  rd:5'd6, op:5'h0E, imm:16'hFFFF, use_imm:1'b1, sx:1'b1, wr:1'b0, a:32'h00000007, b:32'hFFFFFFFF};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick(); tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        wb_write(5'd3, 32'h00000005);
        wb_write(5'd4, 32'h00000007);
        wb_write(5'd10, 32'hDEADBEEF);
        wb_write(5'd11, 32'h00000010);

        // Table: independent instructions issued on consecutive cycles.
        for (int k = 0; k < 6; k++) begin
            drive(vecs[k].rs, vecs[k].rt, vecs[k].rd, vecs[k].op, vecs[k].imm,
                  vecs[k].use_imm, vecs[k].sx, vecs[k].wr);
            #1;
            chk($sformatf("vec%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
            tick();
            chk($sformatf("vec%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_out_a", k), out_a, vecs[k].a);
            chk($sformatf("vec%0d_out_b", k), out_b, vecs[k].b);
            chk($sformatf("vec%0d_out_opcode", k), {27'd0, out_opcode}, {27'd0, vecs[k].op});
            chk($sformatf("vec%0d_out_rd", k), {27'd0, out_rd}, {27'd0, vecs[k].rd});
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // RAW stall released by a same-cycle writeback.
        drive(5'd0, 5'd0, 5'd5, 5'h01, 16'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("raw_prod_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("raw_prod_out_wr", {31'd0, out_wr}, 32'd1);
        chk("raw_prod_out_rd", {27'd0, out_rd}, 32'd5);
        drive(5'd5, 5'd0, 5'd0, 5'h00, 16'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("raw_stall_0", {31'd0, in_ready}, 32'd0);
        tick();
        chk("raw_stall_1", {31'd0, in_ready}, 32'd0);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h00001234;
        #1;
        chk("raw_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        wb_en = 1'b0;
        chk("raw_out_valid", {31'd0, out_valid}, 32'd1);
        chk("raw_out_a", out_a, 32'h00001234);
        #1;
        chk("raw_busy_cleared", {31'd0, in_ready}, 32'd1);
        tick();
        chk("raw_stored_a", out_a, 32'h00001234);

        // Set and clear of the same busy bit in one cycle: the set wins.
        drive(5'd0, 5'd0, 5'd6, 5'h00, 16'd0, 1'b0, 1'b0, 1'b1);
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h00000099;
        #1;
        chk("prio_ready", {31'd0, in_ready}, 32'd1);
        tick();
        wb_en = 1'b0;
        drive(5'd6, 5'd0, 5'd0, 5'h00, 16'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("prio_still_busy", {31'd0, in_ready}, 32'd0);
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000ABCD;
        #1;
        chk("prio_release", {31'd0, in_ready}, 32'd1);
        tick();
        wb_en = 1'b0;
        chk("prio_out_a", out_a, 32'h0000ABCD);
        in_valid = 1'b0;
        tick();

        // Backpressure: output held, new instruction blocked until consumed.
        out_ready = 1'b0;
        drive(5'd3, 5'd4, 5'd9, 5'h02, 16'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(5'd4, 5'd3, 5'd8, 5'h03, 16'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_out_a", c), out_a, 32'h00000005);
            chk($sformatf("bp%0d_out_b", c), out_b, 32'h00000007);
            chk($sformatf("bp%0d_out_opcode", c), {27'd0, out_opcode}, 32'd2);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_b_out_a", out_a, 32'h00000007);
        chk("bp_b_out_b", out_b, 32'h00000005);
        chk("bp_b_out_opcode", {27'd0, out_opcode}, 32'd3);
        in_valid = 1'b0;
        tick();

        // r0: writes ignored, never marked busy.
        wb_write(5'd0, 32'hFFFFFFFF);
        drive(5'd0, 5'd0, 5'd0, 5'h00, 16'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("r0_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("r0_out_a", out_a, 32'd0);
        chk("r0_out_b", out_b, 32'd0);
        drive(5'd0, 5'd0, 5'd0, 5'h00, 16'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("r0_not_busy", {31'd0, in_ready}, 32'd1);
        tick();
        chk("r0_again_a", out_a, 32'd0);
        in_valid = 1'b0;
        tick();

        // Mid-operation reset with r7 busy and an output pending.
        out_ready = 1'b0;
        drive(5'd3, 5'd4, 5'd7, 5'h01, 16'd0, 1'b0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("mr_pending", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h00000055;
        #1;
        chk("mr_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        reset = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_out_a", out_a, 32'd0);
        chk("mr_out_rd", {27'd0, out_rd}, 32'd0);
        chk("mr_out_wr", {31'd0, out_wr}, 32'd0);
        drive(5'd7, 5'd3, 5'd0, 5'h00, 16'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("mr_rs7_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("mr_rs7_out_a", out_a, 32'd0);
        chk("mr_r3_out_b", out_b, 32'd0);
        for (int i = 1; i < 32; i += 2) begin
            drive(5'(i), 5'((i + 1) % 32), 5'd0, 5'h00, 16'd0, 1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("mr_scan%0d_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            chk($sformatf("mr_scan%0d_a", i), out_a, 32'd0);
            chk($sformatf("mr_scan%0d_b", i), out_b, 32'd0);
        end
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
